ddata_rx: RTL and testbench
===========================

// Module: ddata_rx
// PURPOSE
// - Receive end of the directed serial data link: requests bytes with ddataEn, samples ddata on sclk.
// - Deserialises 8 bits LSB-first into bytes and buffers them in a FIFO for the datapath.
// - Sits between the directed-data source (bench or upstream serialiser) and the audio input mux.
// PARAMETERS
// - DEPTH  4  FIFO entries in bytes, power of 2, >=2
// - AW     2  FIFO address width, log2(DEPTH)
// PORTS
// - sclk          in   1  single clock, rising-edge sampling
// - rst_n         in   1  reset, asynchronous, active-low
// - enable        in   1  allow new byte requests
// - ddata         in   1  serial data; source changes it on negedge sclk
// - ddataEn       out  1  request/ready to source, registered
// - rx_data       out  8  FIFO head byte
// - rx_valid      out  1  FIFO non-empty
// - rx_ready      in   1  consumer pops head when rx_valid && rx_ready
// - rx_level      out  AW+1  FIFO occupancy
// - rx_busy       out  1  state != IDLE
// - rx_byte_cnt   out  32 bytes received (only with DDATA_RX_CNT_EN)
// BEHAVIOUR
// - Reset: ddataEn=0, rx_valid=0, rx_data=0, rx_level=0, rx_busy=0, rx_byte_cnt=0, state=IDLE, bitcnt=0.
// - Link rule: ddataEn rises at posedge k; bits 0..7 are sampled at posedges k+1..k+8.
// - Source re-checks ddataEn only between bytes, after driving bit 7; ddataEn therefore changes
//   only at the posedge that samples bit 6, or in IDLE.
// - States: IDLE, RECV (2-bit encoding).
// - IDLE: if enable && free>=1, set ddataEn=1, bitcnt=0 -> RECV. Otherwise stay, ddataEn=0.
// - RECV: each posedge, shreg[bitcnt]=ddata, bitcnt++.
//   - bitcnt==6: cont = enable && free>=2; ddataEn <= cont.
//   - bitcnt==7: push {ddata, shreg[6:0]}; bitcnt=0; cont ? stay RECV : -> IDLE.
// - free = DEPTH - level, taken before this cycle's pop; a simultaneous pop is ignored, so
//   the free check is conservative. Result: no overflow by construction.
// - Back-to-back: with cont=1 there is no gap; byte n+1 bit 0 is sampled at the posedge after byte n bit 7.
// - Push latency: byte visible on rx_data/rx_valid at the posedge after the bit-7 sample.
// - FIFO: simultaneous push and pop is legal at any level, including full, and leaves the level unchanged.
//   Read/write pointers are AW+1 bits and wrap naturally.
// - enable dropping mid-byte: the current byte completes and is pushed; no further request is made.
// - Reset mid-byte: the partial byte is discarded and the FIFO is flushed. Source bits arriving
//   after reset are ignored until the next ddataEn.
// - Empty FIFO: rx_valid=0; rx_ready is ignored and rx_data holds its last value.
// CONFIGURATION
// - DDATA_RX_CNT_EN defined: rx_byte_cnt port present; increments by 1 per push, wraps at 2^32.
// - DDATA_RX_CNT_EN undefined: rx_byte_cnt port and counter absent; all other behaviour is identical.
// STRUCTURE
// - Shared package ser_pkg:
//   - BITS_PER_WORD=8
//   - state encodings ST_IDLE=2'd0, ST_RECV=2'd1
//   - CONT_BIT=6, the request-decision bit index
// - Sub-module byte_fifo (DEPTH, AW): synchronous FIFO with push/pop/level/empty/full.
// - The top holds the FSM, bit counter, shift register and optional counter.
// TESTING
// - Single byte: enable=1, source sends 8'hA5 LSB-first -> rx_data=8'hA5, rx_valid=1 at k+9; ddataEn low from k+7.
// - Stream with rx_ready=1: 16 bytes 8'h00..8'h0F -> no ddataEn gap, all bytes in order, rx_level<=1.
// - Back-pressure with rx_ready=0, DEPTH=4:
//   - send 8'h11..8'h44 -> rx_level=4, ddataEn=0 held.
//   - pop one -> ddataEn reasserts within 2 clocks; byte 8'h55 arrives, no loss.
// - enable=0 asserted at bit 3 of byte 8'h3C -> 8'h3C pushed, ddataEn stays 0, state IDLE.
// - rst_n=0 at bit 4, then released, then 8'h96 sent -> rx_level=1, rx_data=8'h96, with no partial byte before it.
// - DDATA_RX_CNT_EN: 300 bytes sent -> rx_byte_cnt=300; without the macro, the same test compiles without that port.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the directed serial data link: word size,
// receiver FSM state encoding and the bit index at which the receiver
// decides whether to request the next byte.
package ser_pkg;

  localparam int unsigned BITS_PER_WORD = 8;
  localparam int unsigned CONT_BIT      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1
  } state_t;

endpackage

// File: rtl/ddata_rx_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with extra-bit pointers.
// Push and pop in the same cycle are legal at any level, including full.
// While empty, the head output holds the most recently popped byte.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);

  localparam int unsigned LW = AW + 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  last_q;
  logic        do_push;
  logic        do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last_q : mem[rd_ptr[AW-1:0]];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update and held copy of the last byte popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ddata_rx.sv
// ddata_rx: receive end of the directed serial data link.
// Requests bytes with ddataEn, samples ddata LSB-first on rising sclk and
// queues completed bytes in a byte_fifo.
// Optional macro DDATA_RX_CNT_EN adds the rx_byte_cnt port and counter.
module ddata_rx
  import ser_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          ddata,
  output logic          ddataEn,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [AW:0]   rx_level,
  output logic          rx_busy
`ifdef DDATA_RX_CNT_EN
  ,
  output logic [31:0]   rx_byte_cnt
`endif
);

  localparam int unsigned LW       = AW + 1;
  localparam logic [AW:0] LVL_CONT = LW'(DEPTH - 2);
  localparam logic [2:0]  CONT_IDX = 3'(CONT_BIT);
  localparam logic [2:0]  LAST_IDX = 3'(BITS_PER_WORD - 1);

  state_t      state;
  state_t      state_n;
  logic [2:0]  bitcnt;
  logic [2:0]  bitcnt_n;
  logic [6:0]  shreg;
  logic [6:0]  shreg_n;
  logic        en_q;
  logic        en_n;
  logic        push;
  logic [7:0]  push_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        start_ok;
  logic        cont_ok;

  // Level is taken before any same-cycle pop, so both checks are conservative.
  assign start_ok = enable && !fifo_full;
  assign cont_ok  = enable && (rx_level <= LVL_CONT);

  assign ddataEn  = en_q;
  assign rx_valid = !fifo_empty;
  assign rx_busy  = (state != ST_IDLE);

  // Receiver state, bit counter, shift register and request flag.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      en_q   <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      en_q   <= en_n;
    end
  end

  // Next-state, bit capture and push decision.
  always_comb begin
    state_n   = state;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    en_n      = en_q;
    push      = 1'b0;
    push_data = {ddata, shreg};
    unique case (state)
      ST_IDLE: begin
        en_n     = start_ok;
        bitcnt_n = '0;
        if (start_ok) begin
          state_n = ST_RECV;
        end
      end
      ST_RECV: begin
        bitcnt_n = bitcnt + 3'd1;
        for (int unsigned i = 0; i < BITS_PER_WORD - 1; i++) begin
          if (bitcnt == 3'(i)) begin
            shreg_n[i] = ddata;
          end
        end
        // The source only looks at ddataEn after driving bit 7, so the
        // next-byte request is settled while bit 6 is sampled.
        if (bitcnt == CONT_IDX) begin
          en_n = cont_ok;
        end
        if (bitcnt == LAST_IDX) begin
          push     = 1'b1;
          bitcnt_n = '0;
          state_n  = en_q ? ST_RECV : ST_IDLE;
        end
      end
      default: begin
        state_n  = ST_IDLE;
        bitcnt_n = '0;
        en_n     = 1'b0;
      end
    endcase
  end

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (sclk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rx_ready),
    .head      (rx_data),
    .level     (rx_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef DDATA_RX_CNT_EN
  // Count of bytes pushed into the FIFO, wrapping at 2^32.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_cnt <= '0;
    end else if (push) begin
      rx_byte_cnt <= rx_byte_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddata_rx.sv
// Testbench for ddata_rx: a bench-side serial source drives ddata on the
// falling edge in response to ddataEn; expected bytes are queued when
// stimulus is issued and a separate monitor compares every popped byte.
module tb_ddata_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          sclk     = 1'b0;
  logic          rst_n    = 1'b0;
  logic          enable   = 1'b0;
  logic          ddata    = 1'b0;
  logic          rx_ready = 1'b0;
  logic          ddataEn;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW:0]   rx_level;
  logic          rx_busy;
`ifdef DDATA_RX_CNT_EN
  logic [31:0]   rx_byte_cnt;
`endif

  ddata_rx #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .enable   (enable),
    .ddata    (ddata),
    .ddataEn  (ddataEn),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_level (rx_level),
    .rx_busy  (rx_busy)
`ifdef DDATA_RX_CNT_EN
    ,
    .rx_byte_cnt (rx_byte_cnt)
`endif
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q [$];
  logic [7:0] tx_q  [$];
  bit         en_block = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_rise(input string name, output int k);
    k = -1;
    repeat (200) begin
      @(negedge sclk);
      if (ddataEn) begin
        k = cyc;
        break;
      end
    end
    if (k < 0) fail_timeout(name);
  endtask

  task automatic wait_level(input string name, input logic [AW:0] lvl);
    bit ok = 1'b0;
    repeat (200) begin
      @(negedge sclk);
      if (rx_level == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout(name);
  endtask

  // Let the consumer pop until every expected byte is seen and the link is idle.
  task automatic drain(input string name, input int max_cyc);
    bit done = 1'b0;
    @(posedge sclk); #1 rx_ready = 1'b1;
    repeat (max_cyc) begin
      @(negedge sclk);
      if (exp_q.size() == 0 && tx_q.size() == 0 && !rx_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_timeout(name);
    @(posedge sclk); #1 rx_ready = 1'b0;
    @(negedge sclk);
    check({name, "_level_empty"}, 32'(rx_level), 32'd0);
  endtask

  // Serial source: starts a byte after seeing ddataEn, re-checks only after bit 7.
  initial begin : source
    int         idx;
    logic [7:0] cur;
    idx = 8;
    cur = '0;
    forever begin
      @(negedge sclk);
      if (!rst_n) begin
        idx   = 8;
        ddata = 1'b0;
      end else if (idx == 8) begin
        if (ddataEn && tx_q.size() > 0) begin
          cur   = tx_q.pop_front();
          ddata = cur[0];
          idx   = 1;
        end
      end else begin
        ddata = cur[idx];
        idx++;
      end
      enable = (tx_q.size() > 0) && !en_block && rst_n;
    end
  end

  // Monitor: every byte accepted by the consumer is compared in order.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge sclk);
      if (rst_n && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_byte: got %02h, expected no byte", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", 32'(rx_data), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int k;
    int fall_c;
    int val_c;
    int hi;
    int mx;
    int t;

    // Reset values
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    check("rst_ddataEn", 32'(ddataEn), 32'd0);
    check("rst_valid",   32'(rx_valid), 32'd0);
    check("rst_data",    32'(rx_data), 32'd0);
    check("rst_level",   32'(rx_level), 32'd0);
    check("rst_busy",    32'(rx_busy), 32'd0);
    @(posedge sclk); #1 rst_n = 1'b1;

    // Single byte: ddataEn falls at k+7, byte present on the posedge k+9
    exp_q.push_back(8'hA5);
    tx_q.push_back(8'hA5);
    wait_rise("single_rise", k);
    fall_c = -1;
    val_c  = -1;
    repeat (20) begin
      @(negedge sclk);
      if (!ddataEn && fall_c < 0) fall_c = cyc;
      if (rx_valid && val_c < 0) val_c = cyc;
    end
    check("single_en_fall", 32'(fall_c - k), 32'd7);
    check("single_valid_lat", 32'(val_c - k), 32'd8);
    check("single_level", 32'(rx_level), 32'd1);
    check("single_head", 32'(rx_data), 32'hA5);
    drain("single", 100);

    // Stream of 16 bytes with the consumer always ready
    @(posedge sclk); #1 rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      tx_q.push_back(8'(i));
    end
    hi = 0;
    mx = 0;
    t  = 0;
    repeat (400) begin
      @(negedge sclk);
      if (ddataEn) hi++;
      if (int'(rx_level) > mx) mx = int'(rx_level);
      if (exp_q.size() == 0 && tx_q.size() == 0 && !rx_busy) begin
        t = 1;
        break;
      end
    end
    if (t == 0) fail_timeout("stream_done");
    // 15 back-to-back bytes of 8 request cycles plus 7 for the last one
    check("stream_en_high_cycles", 32'(hi), 32'd127);
    check("stream_max_level", 32'(mx), 32'd1);
    drain("stream", 100);

    // Back-pressure: four bytes fill the FIFO, the fifth waits for a pop
    foreach (tx_q[i]) tx_q.delete(i);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    tx_q.push_back(8'h44); tx_q.push_back(8'h55);
    wait_level("bp_fill", 3'd4);
    hi = 0;
    repeat (6) begin
      @(negedge sclk);
      if (ddataEn) hi++;
    end
    check("bp_hold_en_low", 32'(hi), 32'd0);
    check("bp_full_level", 32'(rx_level), 32'd4);
    @(posedge sclk); #1 rx_ready = 1'b1;
    @(posedge sclk); #1 rx_ready = 1'b0;
    t = -1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge sclk);
      if (ddataEn && t < 0) t = i;
    end
    check("bp_reassert_within_2", 32'(t >= 1 && t <= 2), 32'd1);
    wait_level("bp_refill", 3'd4);
    check("bp_head_after_refill", 32'(rx_data), 32'h22);
    drain("bp", 100);

    // enable dropped during bit 3: current byte completes, no new request
    exp_q.push_back(8'h3C);
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'h77);
    @(posedge sclk); #1 rx_ready = 1'b1;
    wait_rise("endrop_rise", k);
    repeat (3) @(posedge sclk);
    #1 en_block = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge sclk);
      if (cyc > k + 7 && ddataEn) hi++;
    end
    check("endrop_no_request", 32'(hi), 32'd0);
    check("endrop_idle", 32'(rx_busy), 32'd0);
    check("endrop_byte_seen", 32'(exp_q.size()), 32'd0);
    check("endrop_level", 32'(rx_level), 32'd0);
    tx_q.delete();
    @(posedge sclk); #1 en_block = 1'b0; rx_ready = 1'b0;

    // Reset mid-byte, then a clean byte
    tx_q.push_back(8'hE1);
    wait_rise("rstmid_rise", k);
    repeat (4) @(posedge sclk);
    #1 rst_n = 1'b0;
    tx_q.delete();
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b1;
    @(negedge sclk);
    check("rstmid_level", 32'(rx_level), 32'd0);
    check("rstmid_busy", 32'(rx_busy), 32'd0);
    check("rstmid_ddataEn", 32'(ddataEn), 32'd0);
    exp_q.push_back(8'h96);
    tx_q.push_back(8'h96);
    wait_rise("rstmid_rise2", k);
    repeat (12) @(negedge sclk);
    check("rstmid_level_after", 32'(rx_level), 32'd1);
    check("rstmid_data_after", 32'(rx_data), 32'h96);
    drain("rstmid", 100);

`ifdef DDATA_RX_CNT_EN
    // Byte counter over 300 streamed bytes
    @(posedge sclk); #1 rst_n = 1'b0;
    @(posedge sclk); #1 rst_n = 1'b1;
    @(negedge sclk);
    check("cnt_reset", rx_byte_cnt, 32'd0);
    @(posedge sclk); #1 rx_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(8'(i));
      tx_q.push_back(8'(i));
    end
    drain("cnt", 4000);
    check("cnt_300", rx_byte_cnt, 32'd300);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
